// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and data_memory.
// slave  : the arbiter's view (requests in, grants/read returns/memory access out).
// master : the environment's view (requesters and the memory model).
interface dmem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Port 0: core load/store unit
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_gnt;
  logic          p0_rvalid;
  logic [DW-1:0] p0_rdata;

  // Port 1: debug/loader master
  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_lock;
  logic          p1_gnt;
  logic          p1_rvalid;
  logic [DW-1:0] p1_rdata;

  // Shared data-memory port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter in front of the single data-memory port.
// Port 0 is the core LSU, port 1 the debug/loader master. Grants are
// combinational (the access happens in the granting cycle); port 1 may
// hold the port with p1_lock. Read data from memory arrives the cycle after
// the granted read and is registered into the issuing port's rdata, so a
// read granted in cycle N shows rvalid/rdata in cycle N+2.
module dmem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic                 clk,
  input logic                 reset,
  dmem_port_arbiter_if.slave  bus
);

  // Arbitration state
  logic          last_gnt_r;   // index of the most recently granted port
  logic          rd_pend_r;    // a read was issued last cycle
  logic          rd_port_r;    // port that issued that read

  // Registered read-return outputs
  logic          p0_rvalid_r;
  logic          p1_rvalid_r;
  logic [DW-1:0] p0_rdata_r;
  logic [DW-1:0] p1_rdata_r;

  // Combinational arbitration results
  logic [1:0]    pick_s;
  logic          gnt0_s;
  logic          gnt1_s;
  logic          gnt_any_s;
  logic          rd_issue_s;

  // Combinational memory-side mux
  logic          mem_we_s;
  logic [AW-1:0] mem_addr_s;
  logic [DW-1:0] mem_wdata_s;

  // Arbitration decision: returns {grant_valid, grant_index}.
  // A lone requester always wins; with both requesting, a held lock gives
  // port 1 the port, otherwise the port that was not granted last wins.
  function automatic logic [1:0] arb_pick(
    input logic req0,
    input logic req1,
    input logic lock1,
    input logic last
  );
    logic [1:0] pick;
    case ({req1, req0})
      2'b01: pick = 2'b10;
      2'b10: pick = 2'b11;
      2'b11: begin
        if (lock1) begin
          pick = 2'b11;
        end else if (last) begin
          pick = 2'b10;
        end else begin
          pick = 2'b11;
        end
      end
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

  // Grant selection; no grant at all while reset is asserted.
  always_comb begin
    pick_s = 2'b00;
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset) begin
      pick_s = 2'b00;
    end else begin
      pick_s = arb_pick(bus.p0_req, bus.p1_req, bus.p1_lock, last_gnt_r);
    end
    gnt0_s = pick_s[1] & ~pick_s[0];
    gnt1_s = pick_s[1] &  pick_s[0];
  end

  // Route the granted port onto the memory bus; drive zeros when idle.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = {AW{1'b0}};
    mem_wdata_s = {DW{1'b0}};
    case ({gnt1_s, gnt0_s})
      2'b01: begin
        mem_we_s    = bus.p0_we;
        mem_addr_s  = bus.p0_addr;
        mem_wdata_s = bus.p0_wdata;
      end
      2'b10: begin
        mem_we_s    = bus.p1_we;
        mem_addr_s  = bus.p1_addr;
        mem_wdata_s = bus.p1_wdata;
      end
      default: begin
        mem_we_s    = 1'b0;
        mem_addr_s  = {AW{1'b0}};
        mem_wdata_s = {DW{1'b0}};
      end
    endcase
  end

  assign gnt_any_s  = gnt0_s | gnt1_s;
  assign rd_issue_s = gnt_any_s & ~mem_we_s;

  // Round-robin pointer and in-flight read tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_r <= 1'b1;
      rd_pend_r  <= 1'b0;
      rd_port_r  <= 1'b0;
    end else begin
      if (gnt_any_s) begin
        last_gnt_r <= gnt1_s;
      end else begin
        last_gnt_r <= last_gnt_r;
      end
      rd_pend_r <= rd_issue_s;
      if (rd_issue_s) begin
        rd_port_r <= gnt1_s;
      end else begin
        rd_port_r <= rd_port_r;
      end
    end
  end

  // Capture returning memory data into the port that issued the read.
  always_ff @(posedge clk) begin
    if (reset) begin
      p0_rvalid_r <= 1'b0;
      p1_rvalid_r <= 1'b0;
      p0_rdata_r  <= {DW{1'b0}};
      p1_rdata_r  <= {DW{1'b0}};
    end else begin
      p0_rvalid_r <= rd_pend_r & ~rd_port_r;
      p1_rvalid_r <= rd_pend_r &  rd_port_r;
      if (rd_pend_r && !rd_port_r) begin
        p0_rdata_r <= bus.mem_rdata;
      end else begin
        p0_rdata_r <= p0_rdata_r;
      end
      if (rd_pend_r && rd_port_r) begin
        p1_rdata_r <= bus.mem_rdata;
      end else begin
        p1_rdata_r <= p1_rdata_r;
      end
    end
  end

  assign bus.p0_gnt    = gnt0_s;
  assign bus.p1_gnt    = gnt1_s;
  assign bus.p0_rvalid = p0_rvalid_r;
  assign bus.p1_rvalid = p1_rvalid_r;
  assign bus.p0_rdata  = p0_rdata_r;
  assign bus.p1_rdata  = p1_rdata_r;

  assign bus.mem_en    = gnt_any_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;

endmodule
